// File: rtl/trivium_wide.sv
`default_nettype none
// ============================================================================
// Module   : trivium_wide
// Purpose  : Trivium keystream generator that applies W bit-rounds per
//            advancing clock cycle (combinationally unrolled). Loads an
//            80-bit key and 80-bit IV, runs INIT_ROUNDS warm-up rounds,
//            then emits W keystream bits per accepted cycle over a
//            valid/ready handshake.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Parameters
//   W           : keystream bits per accepted cycle (1,2,4,8,16,32,64)
//   INIT_ROUNDS : warm-up bit-rounds, multiple of W (1152 for Trivium)
// Ports
//   clk       in   rising-edge clock
//   rst       in   synchronous active-high reset
//   enable    in   global advance enable; low freezes everything
//   start     in   load key/iv and begin initialisation
//   key       in   [79:0] key,  key[i] = K(i+1)
//   iv        in   [79:0] IV,   iv[i]  = IV(i+1)
//   busy      out  high while initialising
//   ks_valid  out  ks_data holds W valid keystream bits
//   ks_ready  in   consumer accepts ks_data when ks_valid is high
//   ks_data   out  [W-1:0] keystream, bit 0 is the earliest bit
// ============================================================================
module trivium_wide #(
    parameter int W           = 8,
    parameter int INIT_ROUNDS = 1152
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         enable,
    input  logic         start,
    input  logic [79:0]  key,
    input  logic [79:0]  iv,
    output logic         busy,
    output logic         ks_valid,
    input  logic         ks_ready,
    output logic [W-1:0] ks_data
);

    // Number of enabled cycles spent in INIT, and a counter wide enough to
    // hold that value without wrapping.
    localparam int c_INIT_CYC = INIT_ROUNDS / W;
    localparam int c_CNT_W    = (c_INIT_CYC < 1) ? 1 : $clog2(c_INIT_CYC + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(c_INIT_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INIT = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t               r_fsm;
    logic [287:0]         r_state;     // r_state[i-1] holds Trivium s(i)
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_busy;
    logic                 r_valid;

    logic [287:0]         w_load;
    logic [287:0]         w_next;
    logic [W-1:0]         w_ks;

    // Initial state layout:
    //   s1..s80    = key      s81..s93   = 0
    //   s94..s173  = iv       s174..s285 = 0
    //   s286..s288 = 1
    assign w_load = {3'b111, 112'b0, iv, 13'b0, key};

    // W chained Trivium rounds. Round j reads the state produced by round
    // j-1 and contributes keystream bit j, so bit 0 is the oldest bit.
    always_comb begin : comb_rounds
        logic [287:0] v_s;
        logic         v_t1;
        logic         v_t2;
        logic         v_t3;
        v_s  = r_state;
        v_t1 = 1'b0;
        v_t2 = 1'b0;
        v_t3 = 1'b0;
        w_ks = '0;
        for (int j = 0; j < W; j++) begin
            v_t1 = v_s[65]  ^ v_s[92];
            v_t2 = v_s[161] ^ v_s[176];
            v_t3 = v_s[242] ^ v_s[287];
            w_ks[j] = v_t1 ^ v_t2 ^ v_t3;
            v_t1 = v_t1 ^ (v_s[90]  & v_s[91])  ^ v_s[170];
            v_t2 = v_t2 ^ (v_s[174] & v_s[175]) ^ v_s[263];
            v_t3 = v_t3 ^ (v_s[285] & v_s[286]) ^ v_s[68];
            // Three shift registers: s1..s93 take t3, s94..s177 take t1,
            // s178..s288 take t2; the top bit of each register drops out.
            v_s = {v_s[286:177], v_t2, v_s[175:93], v_t1, v_s[91:0], v_t3};
        end
        w_next = v_s;
    end

    // Control FSM and state register. A start with enable set always wins,
    // including over a simultaneous consume in RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm   <= ST_IDLE;
            r_state <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
        end else if (enable) begin
            if (start) begin
                r_fsm   <= ST_INIT;
                r_state <= w_load;
                r_cnt   <= '0;
                r_busy  <= 1'b1;
                r_valid <= 1'b0;
            end else begin
                case (r_fsm)
                    ST_INIT: begin
                        r_state <= w_next;
                        r_cnt   <= r_cnt + c_CNT_ONE;
                        if (r_cnt == c_CNT_LAST) begin
                            r_fsm   <= ST_RUN;
                            r_busy  <= 1'b0;
                            r_valid <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (ks_ready) begin
                            r_state <= w_next;
                        end
                    end
                    default: begin
                        r_fsm <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign busy     = r_busy;
    assign ks_valid = r_valid;
    // Keystream is a pure function of the state register, so it is stable
    // whenever the state is held.
    assign ks_data  = w_ks;

endmodule
`default_nettype wire

// File: doc/trivium_wide.md
TRIVIUM_WIDE -- requirements
Module: trivium_wide

Interface
REQ-001 Parameter: W, default 8, keystream bits produced per accepted cycle; legal values 1, 2, 4, 8, 16, 32, 64.
REQ-002 Parameter: INIT_ROUNDS, default 1152, warm-up bit-rounds; SHALL be a multiple of W.
REQ-003 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  in  1  synchronous, active-high reset.
REQ-005 Port: enable  in  1  global advance enable; low freezes all state.
REQ-006 Port: start  in  1  single-cycle request to load key/iv and begin initialisation.
REQ-007 Port: key  in  80  key; key[i] = Trivium K(i+1).
REQ-008 Port: iv  in  80  IV; iv[i] = Trivium IV(i+1).
REQ-009 Port: busy  out  1  high while in INIT.
REQ-010 Port: ks_valid  out  1  ks_data holds W valid keystream bits.
REQ-011 Port: ks_ready  in  1  consumer accepts ks_data when ks_valid also high.
REQ-012 Port: ks_data  out  W  keystream; ks_data[0] = earliest bit in sequence.

Function
REQ-013 Core SHALL hold a 288-bit state s1..s288 and implement the eSTREAM Trivium update (taps 66/93/91/92/171; 162/177/175/176/264; 243/288/286/287/69); one "round" = one bit-update.
REQ-014 Each advance SHALL apply W rounds combinationally unrolled in one cycle; round j of the cycle produces ks_data[j].
REQ-015 FSM states: IDLE, INIT, RUN; encoding free.
REQ-016 Load: start=1 and enable=1 in any state SHALL load s1..s80=K, s81..s93=0, s94..s173=IV, s174..s177=0, s178..s285=0, s286..s288=1, clear round counter, enter INIT (restart mid-INIT or mid-RUN is legal and discards old state).
REQ-017 INIT: each enabled cycle applies W rounds, discards output, increments a counter; after exactly INIT_ROUNDS/W enabled cycles SHALL enter RUN (W=8: 144 cycles; W=64: 18 cycles).
REQ-018 Counter width SHALL be ceil(log2(INIT_ROUNDS/W + 1)) bits; no wrap possible in INIT.
REQ-019 RUN: ks_valid=1; ks_data SHALL be the next W keystream bits computed from current state (combinational from state registers).
REQ-020 RUN: state SHALL advance W rounds only on cycles with enable=1, ks_valid=1, ks_ready=1; otherwise state and ks_data held stable.
REQ-021 ks_valid SHALL be 0 in IDLE and INIT; busy SHALL be 1 only in INIT.
REQ-022 enable=0: no state, counter or FSM change; start ignored; outputs held.
REQ-023 start and ks_ready high in same RUN cycle: load wins; no keystream word is consumed.
REQ-024 Keystream SHALL be bit-identical across all legal W for the same key/iv (W=1 serial stream concatenated).

Reset
REQ-025 rst=1 at clock edge SHALL set FSM=IDLE, state=0, counter=0; rst overrides start and enable.
REQ-026 After reset: busy=0, ks_valid=0, ks_data=0 (derived from zero state).
REQ-027 Reset mid-INIT or mid-RUN SHALL abandon operation; new start required.

Verification
REQ-028 Reset then idle: rst 2 cycles -> busy=0, ks_valid=0, ks_data=0 for 10 cycles with start=0.
REQ-029 W=8, key=0, iv=0, start pulse, enable=1 -> busy high exactly 144 cycles, ks_valid rises next cycle; first 64 words match bit-serial golden Trivium model.
REQ-030 Backpressure: in RUN hold ks_ready=0 for 20 cycles, then toggle randomly -> ks_data stable while stalled, accepted word sequence equals golden model with no loss/duplication.
REQ-031 Enable gaps: toggle enable 50% during INIT and RUN -> INIT takes 144 enabled cycles, output sequence unchanged versus enable=1 run.
REQ-032 Restart: new start (different key) at INIT cycle 70 and again in RUN with ks_ready=1 -> init counts fresh 144 cycles, output matches golden model for last key only.
REQ-033 Width equivalence: W=1, 8, 64 instances, same key/iv (key=80'h0123456789ABCDEF0123, iv=80'hFEDCBA9876543210FEDC) -> first 4096 keystream bits identical.
